color_sensor_sampler: RTL and testbench

Front end of the colour pipeline. Drives the shared filter-select lines of the two TCS3200-style colour sensors (edge and corner) through red, green and blue. In each phase it counts output-frequency pulses from both sensors over a fixed gate window. At the end of a frame it presents six saturated 8-bit counts, updated atomically, to `color_translator`.

---
 rtl/color_pkg.sv | 60 ++++++
 rtl/pulse_counter.sv | 56 +++++
 rtl/color_sensor_sampler.sv | 220 ++++++++++++++++++++++
 tb/tb_color_sensor_sampler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// Shared definitions for the colour pipeline: filter-select encodings,
// channel indices, sampler FSM states and the colour codes used downstream.
package color_pkg;

  // {S2,S3} filter-select encodings for TCS3200-style sensors
  localparam logic [1:0] FILT_RED   = 2'b00;
  localparam logic [1:0] FILT_GREEN = 2'b11;
  localparam logic [1:0] FILT_BLUE  = 2'b01;
  localparam logic [1:0] FILT_CLEAR = 2'b10;

  // Saturation ceiling of the 8-bit pulse counters
  localparam logic [7:0] COUNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    CH_RED   = 2'd0,
    CH_GREEN = 2'd1,
    CH_BLUE  = 2'd2
  } channel_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Colour codes shared with color_translator
  typedef enum logic [2:0] {
    COL_WHITE  = 3'd0,
    COL_ORANGE = 3'd1,
    COL_GREEN  = 3'd2,
    COL_RED    = 3'd3,
    COL_BLUE   = 3'd4,
    COL_YELLOW = 3'd5
  } color_t;

  // Filter lines to drive while sampling a given channel
  function automatic logic [1:0] filter_for(input channel_t ch);
    logic [1:0] f;
    case (ch)
      CH_RED:   f = FILT_RED;
      CH_GREEN: f = FILT_GREEN;
      CH_BLUE:  f = FILT_BLUE;
      default:  f = FILT_CLEAR;
    endcase
    return f;
  endfunction

  // Increment that sticks at COUNT_MAX instead of wrapping
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
    logic [7:0] r;
    if (inc && (v != COUNT_MAX)) begin
      r = v + 8'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/pulse_counter.sv
// One sensor channel: 2-flop synchronizer, registered rising-edge detector
// and a saturating 8-bit counter. next_count is the value the counter takes
// at the coming edge, so a tick in the final gate cycle is not lost.
module pulse_counter
  import color_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sensor,
  input  logic       clear,
  input  logic       enable,
  output logic [7:0] next_count
);

  logic       sync_1;
  logic       sync_2;
  logic       prev;
  logic       tick;
  logic [7:0] count;

  // Synchronize the asynchronous pin and register a one-cycle rising-edge tick
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      prev   <= 1'b0;
      tick   <= 1'b0;
    end else begin
      sync_1 <= sensor;
      sync_2 <= sync_1;
      prev   <= sync_2;
      tick   <= sync_2 & ~prev;
    end
  end

  // Counter update: clear wins, ticks only count while enabled
  always_comb begin
    if (clear) begin
      next_count = 8'd0;
    end else if (enable) begin
      next_count = sat_inc(count, tick);
    end else begin
      next_count = count;
    end
  end

  // Pulse counter register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= 8'd0;
    end else begin
      count <= next_count;
    end
  end

endmodule

// File: rtl/color_sensor_sampler.sv
// Steps both colour sensors through red, green and blue, counts sensor
// pulses over a fixed gate per channel and commits all six counts at once.
module color_sensor_sampler
  import color_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1000,
  parameter int GATE_CYCLES   = 100000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       sensor_edge,
  input  logic       sensor_corner,
  output logic [1:0] filter_sel,
  output logic [7:0] r_edge,
  output logic [7:0] g_edge,
  output logic [7:0] b_edge,
  output logic [7:0] r_corner,
  output logic [7:0] g_corner,
  output logic [7:0] b_corner,
  output logic       busy,
  output logic       valid
);

  localparam int MAX_CYCLES = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] GATE_LAST   = TW'(GATE_CYCLES - 1);

  state_t        state;
  state_t        state_next;
  channel_t      channel;
  channel_t      channel_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic          settle_last;
  logic          gate_last;

  logic          cnt_clear;
  logic          cnt_enable;
  logic          shadow_load;
  logic          commit_load;
  logic [1:0]    filter_next;
  logic          busy_next;
  logic          valid_next;

  logic [7:0]    edge_next_count;
  logic [7:0]    corner_next_count;
  logic [7:0]    sh_r_edge;
  logic [7:0]    sh_g_edge;
  logic [7:0]    sh_r_corner;
  logic [7:0]    sh_g_corner;

  assign settle_last = (timer == SETTLE_LAST);
  assign gate_last   = (timer == GATE_LAST);

  pulse_counter u_edge (
    .clock      (clock),
    .reset_n    (reset_n),
    .sensor     (sensor_edge),
    .clear      (cnt_clear),
    .enable     (cnt_enable),
    .next_count (edge_next_count)
  );

  pulse_counter u_corner (
    .clock      (clock),
    .reset_n    (reset_n),
    .sensor     (sensor_corner),
    .clear      (cnt_clear),
    .enable     (cnt_enable),
    .next_count (corner_next_count)
  );

  // State, channel and phase timer registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      channel <= CH_RED;
      timer   <= '0;
    end else begin
      state   <= state_next;
      channel <= channel_next;
      timer   <= timer_next;
    end
  end

  // Next-state, next-channel and phase timer logic
  always_comb begin
    state_next   = state;
    channel_next = channel;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next   = ST_SETTLE;
          channel_next = CH_RED;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (settle_last) begin
          state_next = ST_COUNT;
        end else begin
          state_next = ST_SETTLE;
        end
      end
      ST_COUNT: begin
        if (gate_last) begin
          case (channel)
            CH_RED: begin
              channel_next = CH_GREEN;
              state_next   = ST_SETTLE;
            end
            CH_GREEN: begin
              channel_next = CH_BLUE;
              state_next   = ST_SETTLE;
            end
            CH_BLUE: begin
              state_next = ST_DONE;
            end
            default: begin
              state_next = ST_IDLE;
            end
          endcase
        end else begin
          state_next = ST_COUNT;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Every state entry starts its timer from zero
    if (state_next != state) begin
      timer_next = '0;
    end else if ((state == ST_SETTLE) || (state == ST_COUNT)) begin
      timer_next = timer + TW'(1);
    end else begin
      timer_next = '0;
    end
  end

  // Datapath controls from the current state; registered outputs from the next state
  always_comb begin
    cnt_clear   = (state == ST_SETTLE);
    cnt_enable  = (state == ST_COUNT);
    shadow_load = (state == ST_COUNT) && gate_last;
    commit_load = (state_next == ST_DONE);
    busy_next   = (state_next != ST_IDLE);
    valid_next  = (state_next == ST_DONE);
    if ((state_next == ST_SETTLE) || (state_next == ST_COUNT)) begin
      filter_next = filter_for(channel_next);
    end else begin
      filter_next = FILT_CLEAR;
    end
  end

  // Registered status and filter-select outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      filter_sel <= FILT_CLEAR;
      busy       <= 1'b0;
      valid      <= 1'b0;
    end else begin
      filter_sel <= filter_next;
      busy       <= busy_next;
      valid      <= valid_next;
    end
  end

  // Capture red and green counts at the end of their gates; blue goes
  // straight to the outputs because it commits on that same edge
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sh_r_edge   <= 8'd0;
      sh_g_edge   <= 8'd0;
      sh_r_corner <= 8'd0;
      sh_g_corner <= 8'd0;
    end else if (shadow_load) begin
      case (channel)
        CH_RED: begin
          sh_r_edge   <= edge_next_count;
          sh_r_corner <= corner_next_count;
        end
        CH_GREEN: begin
          sh_g_edge   <= edge_next_count;
          sh_g_corner <= corner_next_count;
        end
        default: begin
          sh_r_edge <= sh_r_edge;
        end
      endcase
    end
  end

  // Atomic commit of all six counts, visible in the DONE cycle
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_edge   <= 8'd0;
      g_edge   <= 8'd0;
      b_edge   <= 8'd0;
      r_corner <= 8'd0;
      g_corner <= 8'd0;
      b_corner <= 8'd0;
    end else if (commit_load) begin
      r_edge   <= sh_r_edge;
      g_edge   <= sh_g_edge;
      b_edge   <= edge_next_count;
      r_corner <= sh_r_corner;
      g_corner <= sh_g_corner;
      b_corner <= corner_next_count;
    end
  end

endmodule

// File: tb/tb_color_sensor_sampler.sv
// Directed bench for color_sensor_sampler: a small-gate instance for frame
// timing and count checks, and a long-gate instance for saturation.
`timescale 1ns/1ps
module tb_color_sensor_sampler;

  localparam int S    = 4;
  localparam int G    = 20;
  localparam int GSAT = 2000;
  localparam int FR   = 3 * (S + G) + 1;
  localparam int FSAT = 3 * (S + GSAT) + 1;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       sensor_edge = 1'b0;
  logic       sensor_corner = 1'b0;
  logic [1:0] filter_sel;
  logic [7:0] r_edge, g_edge, b_edge, r_corner, g_corner, b_corner;
  logic       busy, valid;
  logic [47:0] outs;

  logic       start_sat = 1'b0;
  logic       sat_edge = 1'b0;
  logic       sat_corner = 1'b0;
  logic [1:0] sat_filter_sel;
  logic [7:0] sat_r_edge, sat_g_edge, sat_b_edge, sat_r_corner, sat_g_corner, sat_b_corner;
  logic       sat_busy, sat_valid;
  logic [47:0] sat_outs;

  logic [47:0] exp_old = 48'd0;
  int checks = 0;
  int errors = 0;

  localparam logic [47:0] F1 = {8'd5, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0};
  localparam logic [47:0] F2 = {8'd0, 8'd2, 8'd5, 8'd2, 8'd5, 8'd2};

  always #5 clock = ~clock;

  assign outs     = {r_edge, g_edge, b_edge, r_corner, g_corner, b_corner};
  assign sat_outs = {sat_r_edge, sat_g_edge, sat_b_edge, sat_r_corner, sat_g_corner, sat_b_corner};

  color_sensor_sampler #(.SETTLE_CYCLES(S), .GATE_CYCLES(G)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .sensor_edge(sensor_edge), .sensor_corner(sensor_corner),
    .filter_sel(filter_sel),
    .r_edge(r_edge), .g_edge(g_edge), .b_edge(b_edge),
    .r_corner(r_corner), .g_corner(g_corner), .b_corner(b_corner),
    .busy(busy), .valid(valid)
  );

  color_sensor_sampler #(.SETTLE_CYCLES(S), .GATE_CYCLES(GSAT)) dut_sat (
    .clock(clock), .reset_n(reset_n), .start(start_sat),
    .sensor_edge(sat_edge), .sensor_corner(sat_corner),
    .filter_sel(sat_filter_sel),
    .r_edge(sat_r_edge), .g_edge(sat_g_edge), .b_edge(sat_b_edge),
    .r_corner(sat_r_corner), .g_corner(sat_g_corner), .b_corner(sat_b_corner),
    .busy(sat_busy), .valid(sat_valid)
  );

  // Square wave level for cycle c: high for the first half of each period
  function automatic logic wave(input int p, input int c);
    if (p == 0) return 1'b0;
    return ((c % p) < (p / 2));
  endfunction

  // One frame; pin levels are set at the negedge of frame cycle c.
  // abort_at != 0 pulls reset_n low in that cycle and checks the cleared state.
  task automatic run_frame(input int er, input int eg, input int eb,
                           input int cr, input int cg, input int cb,
                           input logic [47:0] exp_new, input bit extra_starts,
                           input int abort_at);
    int pe, pc;
    logic [1:0] exp_filt;
    logic [47:0] exp_outs;
    logic exp_valid, exp_busy;
    bit stop;
    stop = 1'b0;
    @(negedge clock);
    start = 1'b1;
    sensor_edge = 1'b0;
    sensor_corner = 1'b0;
    for (int c = 1; c <= FR + 7 && !stop; c++) begin
      @(negedge clock);
      if (abort_at != 0 && c == abort_at + 1) begin
        checks++;
        if (outs !== 48'd0 || busy !== 1'b0 || valid !== 1'b0 || filter_sel !== 2'b10) begin
          errors++;
          $display("FAIL abort_clear: outs=%h busy=%b valid=%b filter=%b, required outs=0 busy=0 valid=0 filter=10",
                   outs, busy, valid, filter_sel);
        end
        reset_n = 1'b1;
        start = 1'b0;
        sensor_edge = 1'b0;
        sensor_corner = 1'b0;
        stop = 1'b1;
      end else begin
        if (c <= S + G) exp_filt = 2'b00;
        else if (c <= 2 * (S + G)) exp_filt = 2'b11;
        else if (c <= 3 * (S + G)) exp_filt = 2'b01;
        else exp_filt = 2'b10;
        exp_outs  = (c >= FR) ? exp_new : exp_old;
        exp_valid = (c == FR);
        exp_busy  = (c <= FR);
        checks++;
        if (valid !== exp_valid) begin
          errors++;
          $display("FAIL valid cycle %0d: got %b, required %b", c, valid, exp_valid);
        end
        checks++;
        if (busy !== exp_busy) begin
          errors++;
          $display("FAIL busy cycle %0d: got %b, required %b", c, busy, exp_busy);
        end
        checks++;
        if (filter_sel !== exp_filt) begin
          errors++;
          $display("FAIL filter_sel cycle %0d: got %b, required %b", c, filter_sel, exp_filt);
        end
        checks++;
        if (outs !== exp_outs) begin
          errors++;
          $display("FAIL outputs cycle %0d: got %h, required %h", c, outs, exp_outs);
        end
        if (c <= S + G) begin pe = er; pc = cr; end
        else if (c <= 2 * (S + G)) begin pe = eg; pc = cg; end
        else if (c <= 3 * (S + G)) begin pe = eb; pc = cb; end
        else begin pe = 0; pc = 0; end
        sensor_edge   = wave(pe, c);
        sensor_corner = wave(pc, c);
        start = extra_starts && (c == 10 || c == 40);
        if (abort_at != 0 && c == abort_at) reset_n = 1'b0;
      end
    end
    if (abort_at == 0) exp_old = exp_new;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (outs !== 48'd0 || filter_sel !== 2'b10 || busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: outs=%h filter=%b busy=%b valid=%b, required 0/10/0/0",
               outs, filter_sel, busy, valid);
    end
    checks++;
    if (sat_outs !== 48'd0 || sat_filter_sel !== 2'b10 || sat_busy !== 1'b0 || sat_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state_sat: outs=%h filter=%b busy=%b valid=%b, required 0/10/0/0",
               sat_outs, sat_filter_sel, sat_busy, sat_valid);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_idle(input int n, input logic [47:0] exp_outs);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      checks++;
      if (outs !== exp_outs || filter_sel !== 2'b10 || busy !== 1'b0 || valid !== 1'b0) begin
        errors++;
        $display("FAIL idle cycle %0d: outs=%h filter=%b busy=%b valid=%b, required outs=%h filter=10 busy=0 valid=0",
                 i, outs, filter_sel, busy, valid, exp_outs);
      end
    end
  endtask

  task automatic test_basic_frame;
    run_frame(4, 0, 10, 0, 0, 0, F1, 1'b0, 0);
  endtask

  task automatic test_atomic_update;
    run_frame(0, 8, 4, 10, 4, 8, F2, 1'b0, 0);
  endtask

  task automatic test_start_while_busy;
    run_frame(4, 0, 10, 0, 0, 0, F1, 1'b1, 0);
  endtask

  task automatic test_reset_mid_frame;
    run_frame(0, 8, 4, 10, 4, 8, F2, 1'b0, 30);
    exp_old = 48'd0;
    test_idle(20, 48'd0);
    run_frame(0, 8, 4, 10, 4, 8, F2, 1'b0, 0);
  endtask

  task automatic test_saturation;
    bit found;
    int vc;
    found = 1'b0;
    vc = 0;
    @(negedge clock);
    start_sat = 1'b1;
    for (int c = 1; c <= FSAT + 50 && !found; c++) begin
      @(negedge clock);
      start_sat = 1'b0;
      if (sat_valid === 1'b1) begin
        found = 1'b1;
        vc = c;
      end
      sat_edge   = wave(4, c);
      sat_corner = wave(4, c + 1);
    end
    checks++;
    if (!found || vc != FSAT) begin
      errors++;
      $display("FAIL sat_valid_cycle: got %0d (found=%0d), required %0d", vc, found, FSAT);
    end
    checks++;
    if (sat_outs !== {6{8'hFF}}) begin
      errors++;
      $display("FAIL sat_counts: got %h, required %h", sat_outs, {6{8'hFF}});
    end
  endtask

  initial begin
    test_reset();
    test_idle(50, 48'd0);
    test_basic_frame();
    test_idle(3, F1);
    test_atomic_update();
    test_idle(3, F2);
    test_start_while_busy();
    test_idle(3, F1);
    test_reset_mid_frame();
    test_idle(3, F2);
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
